// File: rtl/des_pkg.sv
// DES key-schedule constants: PC-1 table, per-round shift amounts, FSM states, rotate helpers.
// Bit numbering throughout follows FIPS 46-3 (index i of a [N:1] vector = FIPS bit i).
package des_pkg;

  localparam int CD_W   = 28;
  localparam int ROUNDS = 16;

  // Source key bit for each CD bit 1..56 (C = 1..28, D = 29..56).
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Entry r-1 holds S[r]; the amounts sum to 28 so C16D16 == C0D0.
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // FIPS left rotate: new bit i = old bit i+n, wrapping at 28.
  function automatic logic [CD_W:1] rot_l(input logic [CD_W:1] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[2:1], x[CD_W:3]} : {x[1], x[CD_W:2]};
  endfunction

  function automatic logic [CD_W:1] rot_r(input logic [CD_W:1] x, input logic [1:0] n);
    return (n == 2'd2) ? {x[CD_W-2:1], x[CD_W:CD_W-1]} : {x[CD_W-1:1], x[CD_W]};
  endfunction

endpackage

// File: rtl/des_pc1.sv
// Combinational PC-1: 64-bit key (parity bits dropped) to 56-bit C0D0, both FIPS-indexed.
module des_pc1
  import des_pkg::*;
(
  input  logic [64:1] key,
  output logic [56:1] cd
);

  for (genvar i = 1; i <= 56; i++) begin : g_bit
    assign cd[i] = key[PC1_TAB[i-1]];
  end

  // Parity bits never reach the schedule.
  logic unused_parity;
  assign unused_parity = ^{key[64], key[56], key[48], key[40],
                           key[32], key[24], key[16], key[8]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: one pre-PC2 round key {D,C} per valid/ready handshake,
// K1..K16 for encrypt or K16..K1 for decrypt; first key valid one cycle after start.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [64:1] key_in,
  input  logic        decrypt,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [56:1] round_key,
  output logic [3:0]  round_idx,
  output logic        done
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  logic [56:1]   pc1_cd;
  state_e        state_q, state_d;
  logic [CD_W:1] c_q, c_d, d_q, d_d;
  logic [4:0]    idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dec_q, dec_d;
  logic [3:0]    sidx;
  logic [1:0]    amt;

  des_pc1 u_pc1 (
    .key (key_in),
    .cd  (pc1_cd)
  );

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    dec_d   = dec_q;
    done_d  = 1'b0;

    // Moving into round idx+1: encrypt uses S[idx+1], decrypt rotates back by S[17-idx].
    sidx = dec_q ? 4'(ROUNDS - int'(idx_q)) : idx_q[3:0];
    amt  = SHIFT_TAB[sidx];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dec_d   = decrypt;
          idx_d   = 5'd1;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          if (decrypt) begin
            c_d = pc1_cd[CD_W:1];
            d_d = pc1_cd[2*CD_W:CD_W+1];
          end else begin
            c_d = rot_l(pc1_cd[CD_W:1], SHIFT_TAB[0]);
            d_d = rot_l(pc1_cd[2*CD_W:CD_W+1], SHIFT_TAB[0]);
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 5'd0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (vld_q && rk_ready) begin
          if (idx_q == LAST_ROUND) begin
            state_d = IDLE;
            idx_d   = 5'd0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
            c_d   = dec_q ? rot_r(c_q, amt) : rot_l(c_q, amt);
            d_d   = dec_q ? rot_r(d_q, amt) : rot_l(d_q, amt);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dec_q   <= dec_d;
    end
  end

  assign busy      = busy_q;
  assign rk_valid  = vld_q;
  assign round_key = {d_q, c_q};
  // The 4-bit port cannot hold 16; round 16 presents as 0 alongside rk_valid=1.
  assign round_idx = idx_q[3:0];
  assign done      = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: cumulative-shift reference model plus FIPS example vectors.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [64:1] key_in = '0;
  logic        decrypt = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rk_ready = 1'b0;
  logic        busy, rk_valid, done;
  logic [56:1] round_key;
  logic [3:0]  round_idx;

  int checks = 0;
  int errors = 0;

  des_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .decrypt   (decrypt),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int SH  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Key r of the schedule: C0/D0 rotated left by the cumulative shift through round r.
  function automatic logic [56:1] model_key(input logic [64:1] k, input int r);
    logic [56:1] cd0, res;
    int sh;
    for (int i = 1; i <= 56; i++) cd0[i] = k[PC1[i-1]];
    sh = 0;
    for (int j = 1; j <= r; j++) sh += SH[j-1];
    for (int i = 1; i <= 28; i++) begin
      res[i]    = cd0[((i - 1 + sh) % 28) + 1];
      res[28+i] = cd0[28 + ((i - 1 + sh) % 28) + 1];
    end
    return res;
  endfunction

  function automatic logic [64:1] to_key(input logic [63:0] hex);
    logic [64:1] v;
    for (int i = 1; i <= 64; i++) v[i] = hex[64-i];
    return v;
  endfunction

  function automatic logic [55:0] fips56(input logic [56:1] rk);
    logic [55:0] h;
    for (int i = 1; i <= 56; i++) h[56-i] = rk[i];
    return h;
  endfunction

  function automatic logic [47:0] pc2hex(input logic [56:1] rk);
    logic [47:0] h;
    for (int j = 1; j <= 48; j++) h[48-j] = rk[PC2[j-1]];
    return h;
  endfunction

  // Protocol-level reference: which key of which run should be on the outputs.
  logic        m_run = 1'b0, m_done = 1'b0, m_dec = 1'b0, m_known = 1'b0;
  int          m_pos = 0;
  logic [64:1] m_key = '0;
  logic [56:1] m_rk = '0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_rk = '0; m_known = 1'b1;
    end else if (m_run) begin
      if (abort) begin
        m_run = 1'b0; m_pos = 0; m_known = 1'b0;
      end else if (rk_ready) begin
        if (m_pos == 16) begin
          m_run = 1'b0; m_pos = 0; m_done = 1'b1;
        end else begin
          m_pos++;
          m_rk = model_key(m_key, m_dec ? 17 - m_pos : m_pos);
        end
      end
    end else if (start) begin
      m_run = 1'b1; m_pos = 1; m_dec = decrypt; m_key = key_in; m_known = 1'b1;
      m_rk = model_key(key_in, decrypt ? 16 : 1);
    end
    #1;
    chk("cyc_busy", busy, m_run);
    chk("cyc_rk_valid", rk_valid, m_run);
    chk("cyc_round_idx", round_idx, m_pos[3:0]);
    chk("cyc_done", done, m_done);
    if (m_known) chk("cyc_round_key", round_key, m_rk);
  end

  logic [56:1] cap [1:16];
  logic [56:1] enc [1:16];
  int hs;

  // One run with ready held high except for the optional stall/abort/start-poke/reset events.
  task automatic run(input logic [64:1] k, input logic dec, input int stall_r, input int abort_r,
                     input int poke_r, input int rst_r, input logic [64:1] k2);
    int stalls, r;
    logic [56:1] held;
    bit ended;
    hs = 0; stalls = 0; ended = 0; held = '0;
    @(negedge clk);
    key_in = k; decrypt = dec; start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("latency_valid", rk_valid, 1'b1);
    chk("first_idx", round_idx, 4'd1);
    for (int cyc = 0; cyc < 100 && !ended; cyc++) begin
      r = hs + 1;
      if (r == abort_r) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", rk_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        repeat (3) begin
          chk("abort_no_done", done, 1'b0);
          @(negedge clk);
        end
        return;
      end else if (r == rst_r) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", rk_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_idx", round_idx, 4'd0);
        chk("rst_key", round_key, 56'd0);
        return;
      end else if (r == stall_r && stalls < 5) begin
        if (stalls == 0) held = round_key;
        else chk("stall_key_hold", round_key, held);
        chk("stall_idx_hold", round_idx, r[3:0]);
        rk_ready = 1'b0;
        stalls++;
        @(negedge clk);
      end else begin
        if (r == poke_r) begin
          start = 1'b1; key_in = k2;
        end
        chk("idx_seq", round_idx, r[3:0]);
        rk_ready = 1'b1;
        cap[r] = round_key;
        hs++;
        @(negedge clk);
        start = 1'b0; key_in = k;
        if (hs == 16) ended = 1;
      end
    end
    chk("handshakes", hs, 16);
    if (ended) begin
      chk("done_pulse", done, 1'b1);
      chk("end_valid", rk_valid, 1'b0);
      chk("end_busy", busy, 1'b0);
      @(negedge clk);
      chk("done_once", done, 1'b0);
    end
  endtask

  initial begin
    logic [64:1] k, kp, k2;
    k  = to_key(64'h133457799BBCDFF1);
    k2 = to_key(64'h0E329232EA6D0D73);
    kp = k;
    for (int j = 1; j <= 8; j++) kp[8*j] = ~kp[8*j];

    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", rk_valid, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_idx", round_idx, 4'd0);
    chk("reset_key", round_key, 56'd0);
    rst = 1'b0;

    chk("model_k1_cd", fips56(model_key(k, 1)), 56'hE19955FAACCF1E);
    chk("model_k1_pc2", pc2hex(model_key(k, 1)), 48'h1B02EFFC7072);
    chk("model_k16_pc2", pc2hex(model_key(k, 16)), 48'hCB3D8B0E17F5);

    run(k, 1'b0, 0, 0, 0, 0, k);
    chk("enc_k1_cd", fips56(cap[1]), 56'hE19955FAACCF1E);
    chk("enc_k1_pc2", pc2hex(cap[1]), 48'h1B02EFFC7072);
    chk("enc_k16_pc2", pc2hex(cap[16]), 48'hCB3D8B0E17F5);
    for (int r = 1; r <= 16; r++) enc[r] = cap[r];

    run(k, 1'b1, 0, 0, 0, 0, k);
    chk("dec_k1_pc2", pc2hex(cap[1]), 48'hCB3D8B0E17F5);
    chk("dec_k16_pc2", pc2hex(cap[16]), 48'h1B02EFFC7072);
    for (int r = 1; r <= 16; r++) chk("dec_reversed", cap[r], enc[17-r]);

    run(k, 1'b0, 3, 0, 0, 0, k);
    for (int r = 1; r <= 16; r++) chk("stall_keys", cap[r], enc[r]);

    run(k, 1'b0, 0, 7, 0, 0, k);
    run(k, 1'b0, 0, 0, 0, 0, k);
    chk("after_abort_k1", cap[1], enc[1]);

    run(k, 1'b0, 0, 0, 5, 0, k2);
    for (int r = 1; r <= 16; r++) chk("poke_keys", cap[r], enc[r]);

    run(kp, 1'b0, 0, 0, 0, 0, kp);
    for (int r = 1; r <= 16; r++) chk("parity_keys", cap[r], enc[r]);

    run(k, 1'b0, 0, 0, 0, 10, k);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
